// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - opcodes, control states and arithmetic helpers for the multiply/divide unit
package xalu_pkg;

    typedef enum logic [3:0] {
        XALU_NONE  = 4'd0,
        XALU_MULT  = 4'd1,
        XALU_MULTU = 4'd2,
        XALU_DIV   = 4'd3,
        XALU_DIVU  = 4'd4,
        XALU_MTHI  = 4'd5,
        XALU_MTLO  = 4'd6,
        XALU_MFHI  = 4'd7,
        XALU_MFLO  = 4'd8
    } xalu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } xalu_state_e;

    // Full 64-bit product; operands are widened first so the low 64 bits are exact.
    function automatic logic [63:0] mul64(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        is_signed
    );
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ext_a * ext_b;
    endfunction

    // Returns {remainder, quotient}. Signed form divides magnitudes, then applies
    // sign: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div64(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        is_signed
    );
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] mag_q;
        logic [31:0] mag_r;
        logic [31:0] quot;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            mag_q = 32'd0;
            mag_r = 32'd0;
        end else begin
            mag_q = mag_a / mag_b;
            mag_r = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        rem  = neg_a ? (~mag_r + 32'd1) : mag_r;
        return {rem, quot};
    endfunction

endpackage

// File: rtl/xalu.sv
// rtl/xalu.sv - multi-cycle multiply/divide unit with HI/LO registers for the E stage
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] XALUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    xalu_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_is_mult;
    logic        w_is_div;
    logic        w_b_zero;
    logic [63:0] w_prod;
    logic [63:0] w_divres;

    assign w_is_mult = (op == XALU_MULT) || (op == XALU_MULTU);
    assign w_is_div  = (op == XALU_DIV)  || (op == XALU_DIVU);
    assign w_b_zero  = (B == 32'd0);
    assign w_prod    = mul64(A, B, op == XALU_MULT);
    assign w_divres  = div64(A, B, op == XALU_DIV);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_mult) begin
                            r_pend_hi <= w_prod[63:32];
                            r_pend_lo <= w_prod[31:0];
                            r_cnt     <= MULT_CNT;
                            r_state   <= ST_RUN;
                        end else if (w_is_div) begin
                            // Divide by zero still occupies the unit, but commits the old HI/LO.
                            if (w_b_zero) begin
                                r_pend_hi <= r_hi;
                                r_pend_lo <= r_lo;
                            end else begin
                                r_pend_hi <= w_divres[63:32];
                                r_pend_lo <= w_divres[31:0];
                            end
                            r_cnt   <= DIV_CNT;
                            r_state <= ST_RUN;
                        end else if (op == XALU_MTHI) begin
                            r_hi <= A;
                        end else if (op == XALU_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        XALUOut = 32'd0;
        if (op == XALU_MFHI) begin
            XALUOut = r_hi;
        end else if (op == XALU_MFLO) begin
            XALUOut = r_lo;
        end
    end

endmodule

// File: tb/tb_xalu.sv
// tb/tb_xalu.sv - self-checking bench for xalu: vector table, corner sequences, random vs model
module tb_xalu;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] XALUOut;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .XALUOut (XALUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one op for a single cycle, then count busy cycles (bounded).
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [31:0] xout);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        #1 xout = XALUOut;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Reference model: 64-bit integer arithmetic straight from the op definitions.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [31:0] xout);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        cycles = 0;
        xout = 32'd0;
        case (o)
            4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; cycles = 5; end
            4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; cycles = 5; end
            4'd3: begin
                cycles = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
            end
            4'd4: begin
                cycles = 10;
                if (b != 0) begin q = ua / ub; r = ua % ub; m_hi = r[31:0]; m_lo = q[31:0]; end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            4'd7: xout = m_hi;
            4'd8: xout = m_lo;
            default: ;
        endcase
    endtask

    vec_t vecs[14];

    initial begin
        int          cyc;
        int          exp_cyc;
        logic [31:0] xo;
        logic [31:0] exp_xo;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{4'd5, 32'h00001234, 32'd0,        0,  32'h00001234, 32'h00000003};
        vecs[5]  = '{4'd3, 32'd5,        32'd0,        10, 32'h00001234, 32'h00000003};
        vecs[6]  = '{4'd6, 32'h0000CAFE, 32'd9,        0,  32'h00001234, 32'h0000CAFE};
        vecs[7]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[8]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
        vecs[10] = '{4'd4, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{4'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[12] = '{4'd0, 32'd11,       32'd22,       0,  32'h00000001, 32'hFFFFFFFD};
        vecs[13] = '{4'd15, 32'd33,      32'd44,       0,  32'h00000001, 32'hFFFFFFFD};

        reset_n = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        // Vector table, applied back to back.
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, xo);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
        end

        op = 4'd7; #1 check("mfhi_out", XALUOut, 32'h00000001);
        op = 4'd8; #1 check("mflo_out", XALUOut, 32'hFFFFFFFD);
        op = 4'd1; #1 check("nonmf_out", XALUOut, 32'd0);
        op = 4'd0;

        // MULT requests on busy cycles 2 and 3 of a DIV are ignored.
        @(negedge clk);
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == 2 || cyc == 3) begin
                start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd3;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;
        check("ign_cycles", 32'(cyc), 32'd10);
        check("ign_hi", HI, 32'd2);
        check("ign_lo", LO, 32'd14);
        @(negedge clk);
        check("ign_no_mult", {31'd0, busy}, 32'd0);

        // Reset on cycle 3 of a MULT discards the product.
        @(negedge clk);
        start = 1'b1; op = 4'd1; A = 32'h00001000; B = 32'h00001000;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        repeat (8) @(negedge clk);
        check("midrst_lo_later", LO, 32'd0);
        check("midrst_busy_later", {31'd0, busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Random ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, exp_cyc, exp_xo);
            do_op(ro, ra, rb, cyc, xo);
            check($sformatf("rnd%0d_op%0d_cycles", i, ro), 32'(cyc), 32'(exp_cyc));
            check($sformatf("rnd%0d_op%0d_hi", i, ro), HI, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, ro), LO, m_lo);
            if (ro == 4'd7 || ro == 4'd8)
                check($sformatf("rnd%0d_op%0d_xout", i, ro), xo, exp_xo);
        end

        // Reset held 2 cycles while a MULT is in flight.
        @(negedge clk);
        start = 1'b1; op = 4'd2; A = $urandom | 32'h1; B = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        op = 4'd7;
        #1;
        check("final_rst_busy", {31'd0, busy}, 32'd0);
        check("final_rst_hi", HI, 32'd0);
        check("final_rst_lo", LO, 32'd0);
        check("final_rst_mfhi", XALUOut, 32'd0);
        op = 4'd0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
